// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell stepped LSB first over WIDTH-bit operands.
// Optional subtract support is enabled by defining SERIAL_SUB_EN (adds the sub port).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             readyEn_q;

    logic             accept;
    logic             lastStep;
    logic             stepSum;
    logic             stepCarry;
    logic [WIDTH-1:0] bLoad;
    logic             carryLoad;

    // readyEn_q keeps in_ready low until the first edge that sees rst_n high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            readyEn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            readyEn_q <= 1'b1;
        end
    end

    assign accept   = in_valid && in_ready;
    assign lastStep = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (lastStep) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && readyEn_q;
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

`ifdef SERIAL_SUB_EN
    // Subtraction is a + ~b + 1, so cin is overridden by the forced carry
    assign bLoad     = sub ? ~b : b;
    assign carryLoad = sub ? 1'b1 : cin;
`else
    assign bLoad     = b;
    assign carryLoad = cin;
`endif

    assign stepSum   = aSh_q[0] ^ bSh_q[0] ^ carry_q;
    assign stepCarry = (aSh_q[0] & bSh_q[0]) | (carry_q & (aSh_q[0] ^ bSh_q[0]));

    always_comb begin
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    aSh_d   = a;
                    bSh_d   = bLoad;
                    carry_d = carryLoad;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end
            end
            RUN: begin
                sum_d   = {stepSum, sum_q[WIDTH-1:1]};
                aSh_d   = aSh_q >> 1;
                bSh_d   = bSh_q >> 1;
                carry_d = stepCarry;
                if (lastStep) begin
                    cout_d = stepCarry;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aSh_q   <= '0;
            bSh_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
